phase_wrap_ctrl: RTL and testbench
==================================

// Module: phase_wrap_ctrl
// PURPOSE
//  Run sequencer and configuration controller for the phase-wrapping accumulator datapath.
//  Loads and validates the wrap bounds through a valid/ready handshake.
//  On start: clears the accumulator, enables it for a programmed number of samples,
//  drains the datapath pipeline, then pulses done.
//  Counts wrap events reported by the datapath during the run.
// PARAMETERS
//  WIDTH     14  datapath sample width; bounds are WIDTH+1 bits signed
//  LEN_W     32  run-length counter width
//  CNT_W     16  wrap-event counter width (saturating)
//  CLR_CYC    2  cycles acc_clr_o is held high (>=1)
//  PIPE_LAT   2  datapath latency drained after RUN (>=1)
// PORTS
//  clk_i          in   1        clock; all logic on rising edge
//  rstn_i         in   1        asynchronous reset, active-low
//  cfg_valid_i    in   1        bound update request
//  cfg_ready_o    out  1        1 iff state==IDLE (combinational state decode)
//  cfg_lower_i    in   WIDTH+1  signed requested lower bound
//  cfg_upper_i    in   WIDTH+1  signed requested upper bound
//  cfg_err_o      out  1        sticky: last config rejected
//  lower_bound_o  out  WIDTH+1  signed active lower bound to datapath
//  upper_bound_o  out  WIDTH+1  signed active upper bound to datapath
//  start_i        in   1        start run (sampled in IDLE only)
//  run_len_i      in   LEN_W    samples to accumulate, latched on start
//  abort_i        in   1        abort run
//  wrap_up_i      in   1        datapath wrapped above upper bound
//  wrap_dn_i      in   1        datapath wrapped below lower bound
//  acc_clr_o      out  1        datapath accumulator clear
//  acc_en_o       out  1        datapath accumulate enable
//  busy_o         out  1        state != IDLE
//  done_o         out  1        1-cycle pulse at run end
//  wrap_up_cnt_o  out  CNT_W    up-wrap count of current/last run
//  wrap_dn_cnt_o  out  CNT_W    down-wrap count of current/last run
// BEHAVIOUR
//  Reset values:
//   - state IDLE, lower_bound_o=0, upper_bound_o=2^WIDTH-1 (0x3FFF at default WIDTH).
//   - acc_clr_o, acc_en_o, done_o, busy_o, cfg_err_o = 0; counters 0; cfg_ready_o=1.
//  Outputs: acc_clr_o, acc_en_o, done_o are Moore decodes of the registered state (no extra delay).
//  FSM states:
//   - IDLE->CLEAR: on start_i when run_len_i!=0; run_len_i==0 is ignored.
//   - CLEAR (CLR_CYC cycles; acc_clr_o=1, counters zeroed)->RUN.
//   - RUN (run_len cycles; acc_en_o=1)->DRAIN.
//   - DRAIN (PIPE_LAT cycles; acc_en_o=0)->DONE.
//   - DONE (1 cycle; done_o=1)->IDLE.
//  Run timing: start sampled at edge k -> acc_clr_o high cycles k+1..k+CLR_CYC.
//   acc_en_o high for exactly run_len cycles after that; done_o one cycle after DRAIN ends.
//  Config handshake:
//   - A transfer occurs when cfg_valid_i & cfg_ready_o.
//   - If cfg_lower_i < cfg_upper_i: bounds update at that edge and cfg_err_o clears.
//   - Otherwise: bounds unchanged and cfg_err_o sets.
//   - Bounds are never changed outside IDLE.
//  Simultaneous start_i and cfg transfer in IDLE: both accepted; the new bounds are active from CLEAR.
//  start_i outside IDLE: ignored (no queueing).
//  abort_i: highest priority.
//   - In CLEAR/RUN/DRAIN/DONE -> IDLE at next edge.
//   - acc_en_o, acc_clr_o drop that cycle; no done_o.
//   - Counters hold their values; abort_i in IDLE has no effect.
//  Wrap counting: active in RUN and DRAIN only.
//   - wrap_up_i and wrap_dn_i in the same cycle both count.
//   - Each counter saturates at 2^CNT_W-1.
//   - Counts hold from DONE until the next CLEAR.
//  Reset asserted mid-run: immediate return to reset values; bounds revert to defaults.
// TESTING
//  1. Reset release -> bounds 0/0x3FFF, cfg_ready_o=1, busy_o=0, all pulses 0.
//  2. Valid cfg (-100, 500) in IDLE -> bounds -100/500 next cycle, cfg_err_o=0.
//     Then cfg (7, 7) -> bounds unchanged, cfg_err_o=1.
//  3. start at edge k, run_len=4 -> acc_clr_o cycles k+1..k+2, acc_en_o k+3..k+6.
//     done_o only at cycle k+9; busy_o high k+1..k+9.
//  4. run_len=10 with 3 wrap_up pulses + 1 cycle of up&dn during RUN, 1 dn pulse in DRAIN -> counts up=4, dn=2.
//  5. abort_i during the 2nd RUN cycle -> IDLE next edge, acc_en_o low, no done_o.
//     A cfg is then accepted next cycle.
//  6. start with run_len=0 -> stays IDLE; start_i while busy -> ignored.
//     CNT_W=2 with 5 up pulses -> wrap_up_cnt_o=3.

Source files
------------

// File: rtl/phase_wrap_ctrl.sv
// -----------------------------------------------------------------------------
// phase_wrap_ctrl
// Run sequencer and configuration controller for the phase-wrapping
// accumulator datapath.
//
// A run goes IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE:
//   CLEAR  CLR_CYC cycles with acc_clr_o high; wrap counters zeroed
//   RUN    run_len cycles with acc_en_o high
//   DRAIN  PIPE_LAT cycles so results still in the datapath pipeline settle
//   DONE   one cycle with done_o high
// Wrap events are counted during RUN and DRAIN, saturating at 2^CNT_W-1.
// Bounds can only be loaded in IDLE, through a valid/ready handshake.
//
// Ports
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o     bound update handshake
//   cfg_lower_i / cfg_upper_i     requested signed bounds (WIDTH+1 bits)
//   cfg_err_o                     sticky: last offered config was rejected
//   lower_bound_o / upper_bound_o active signed bounds to the datapath
//   start_i, run_len_i            start a run of run_len_i samples
//   abort_i                       abandon the current run
//   wrap_up_i / wrap_dn_i         wrap events reported by the datapath
//   acc_clr_o / acc_en_o          datapath accumulator clear / enable
//   busy_o, done_o                run in progress / one-cycle end pulse
//   wrap_up_cnt_o / wrap_dn_cnt_o wrap counts of the current or last run
// -----------------------------------------------------------------------------
module phase_wrap_ctrl #(
  parameter int WIDTH    = 14,
  parameter int LEN_W    = 32,
  parameter int CNT_W    = 16,
  parameter int CLR_CYC  = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH:0]   cfg_lower_i,
  input  logic [WIDTH:0]   cfg_upper_i,
  output logic             cfg_err_o,
  output logic [WIDTH:0]   lower_bound_o,
  output logic [WIDTH:0]   upper_bound_o,
  input  logic             start_i,
  input  logic [LEN_W-1:0] run_len_i,
  input  logic             abort_i,
  input  logic             wrap_up_i,
  input  logic             wrap_dn_i,
  output logic             acc_clr_o,
  output logic             acc_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] wrap_up_cnt_o,
  output logic [CNT_W-1:0] wrap_dn_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Terminal values of the shared phase counter for the fixed-length phases.
  localparam logic [LEN_W-1:0] CLR_LAST   = LEN_W'(CLR_CYC - 1);
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(PIPE_LAT - 1);

  // Default upper bound is 2^WIDTH-1: positive full scale of the sample width.
  localparam logic [WIDTH:0] UPPER_RST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [WIDTH:0]   lower_q, lower_d;
  logic [WIDTH:0]   upper_q, upper_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
  logic [CNT_W-1:0] dn_cnt_q, dn_cnt_d;

  logic idle;
  logic counting;

  assign idle     = (state_q == S_IDLE);
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    // NOTE: every combinational output takes its hold value first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    run_len_d   = run_len_q;
    lower_d     = lower_q;
    upper_d     = upper_q;
    err_d       = err_q;
    up_cnt_d    = up_cnt_q;
    dn_cnt_d    = dn_cnt_q;

    // Config transfer; ready is the IDLE decode, so bounds never move mid-run.
    if (cfg_valid_i && idle) begin
      if ($signed(cfg_lower_i) < $signed(cfg_upper_i)) begin
        lower_d = cfg_lower_i;
        upper_d = cfg_upper_i;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && (run_len_i != '0)) begin
          state_d     = S_CLEAR;
          phase_cnt_d = '0;
          run_len_d   = run_len_i;
          // Zeroing on entry keeps the counts at 0 for all of CLEAR.
          up_cnt_d    = '0;
          dn_cnt_d    = '0;
        end
      end
      S_CLEAR: begin
        if (phase_cnt_q == CLR_LAST) begin
          state_d     = S_RUN;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + LEN_W'(1);
        end
      end
      S_RUN: begin
        if (phase_cnt_q == run_len_q - LEN_W'(1)) begin
          state_d     = S_DRAIN;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (phase_cnt_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + LEN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        phase_cnt_d = '0;
      end
    endcase

    if (counting) begin
      if (wrap_up_i && (up_cnt_q != CNT_MAX)) up_cnt_d = up_cnt_q + CNT_W'(1);
      if (wrap_dn_i && (dn_cnt_q != CNT_MAX)) dn_cnt_d = dn_cnt_q + CNT_W'(1);
    end

    // Abort wins over every transition above; counts freeze where they stand.
    if (abort_i && !idle) begin
      state_d     = S_IDLE;
      phase_cnt_d = '0;
      up_cnt_d    = up_cnt_q;
      dn_cnt_d    = dn_cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same clock edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= '0;
      run_len_q   <= '0;
      lower_q     <= '0;
      upper_q     <= UPPER_RST;
      err_q       <= 1'b0;
      up_cnt_q    <= '0;
      dn_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      run_len_q   <= run_len_d;
      lower_q     <= lower_d;
      upper_q     <= upper_d;
      err_q       <= err_d;
      up_cnt_q    <= up_cnt_d;
      dn_cnt_q    <= dn_cnt_d;
    end
  end

  // Moore decodes of the registered state.
  assign cfg_ready_o   = idle;
  assign busy_o        = !idle;
  assign acc_clr_o     = (state_q == S_CLEAR);
  assign acc_en_o      = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign cfg_err_o     = err_q;
  assign lower_bound_o = lower_q;
  assign upper_bound_o = upper_q;
  assign wrap_up_cnt_o = up_cnt_q;
  assign wrap_dn_cnt_o = dn_cnt_q;

endmodule

// File: tb/tb_phase_wrap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phase_wrap_ctrl
// Scoreboard bench. Each run issued by the stimulus process is described as a
// cycle-by-cycle list of expected outputs computed from the run length, the
// fixed phase lengths and the wrap pulses it will drive; config offers push the
// resulting bound/err values. A monitor on the falling edge pops and compares.
// A second instance with CNT_W=2 shares the inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_phase_wrap_ctrl;

  localparam int WIDTH    = 14;
  localparam int LEN_W    = 32;
  localparam int CNT_W    = 16;
  localparam int CLR_CYC  = 2;
  localparam int PIPE_LAT = 2;
  localparam int UP_RST   = (1 << WIDTH) - 1;

  logic             clk, rstn;
  logic             cfg_valid_i, cfg_ready_o, cfg_err_o;
  logic [WIDTH:0]   cfg_lower_i, cfg_upper_i, lower_bound_o, upper_bound_o;
  logic             start_i, abort_i, wrap_up_i, wrap_dn_i;
  logic [LEN_W-1:0] run_len_i;
  logic             acc_clr_o, acc_en_o, busy_o, done_o;
  logic [CNT_W-1:0] wrap_up_cnt_o, wrap_dn_cnt_o;

  logic             s_ready, s_err, s_clr, s_en, s_busy, s_done;
  logic [WIDTH:0]   s_lo, s_hi;
  logic [1:0]       s_up_cnt, s_dn_cnt;

  phase_wrap_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W),
                    .CLR_CYC(CLR_CYC), .PIPE_LAT(PIPE_LAT)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_lower_i(cfg_lower_i), .cfg_upper_i(cfg_upper_i), .cfg_err_o(cfg_err_o),
    .lower_bound_o(lower_bound_o), .upper_bound_o(upper_bound_o),
    .start_i(start_i), .run_len_i(run_len_i), .abort_i(abort_i),
    .wrap_up_i(wrap_up_i), .wrap_dn_i(wrap_dn_i),
    .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o), .busy_o(busy_o), .done_o(done_o),
    .wrap_up_cnt_o(wrap_up_cnt_o), .wrap_dn_cnt_o(wrap_dn_cnt_o)
  );

  phase_wrap_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(2),
                    .CLR_CYC(CLR_CYC), .PIPE_LAT(PIPE_LAT)) u_sat (
    .clk_i(clk), .rstn_i(rstn),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(s_ready),
    .cfg_lower_i(cfg_lower_i), .cfg_upper_i(cfg_upper_i), .cfg_err_o(s_err),
    .lower_bound_o(s_lo), .upper_bound_o(s_hi),
    .start_i(start_i), .run_len_i(run_len_i), .abort_i(abort_i),
    .wrap_up_i(wrap_up_i), .wrap_dn_i(wrap_dn_i),
    .acc_clr_o(s_clr), .acc_en_o(s_en), .busy_o(s_busy), .done_o(s_done),
    .wrap_up_cnt_o(s_up_cnt), .wrap_dn_cnt_o(s_dn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int due;
    bit idle;
    bit clr, en, done, busy;
    int up, dn;
  } exp_t;

  typedef struct {
    int                    due;
    logic signed [WIDTH:0] lo, hi;
    bit                    err;
  } cfg_exp_t;

  exp_t     trace_q[$];
  cfg_exp_t cfg_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic signed [WIDTH:0] e_lo, e_hi;
  bit                    e_err;
  int                    held_up, held_dn;

  always @(negedge clk) begin
    if (!rstn) begin
      trace_q.delete();
      cfg_q.delete();
      e_lo = '0; e_hi = (WIDTH+1)'(UP_RST); e_err = 1'b0;
      held_up = 0; held_dn = 0;
      check("rst_lower", $signed(lower_bound_o), 0);
      check("rst_upper", $signed(upper_bound_o), UP_RST);
      check("rst_ready", cfg_ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_clr", acc_clr_o, 0);
      check("rst_en", acc_en_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", cfg_err_o, 0);
      check("rst_up_cnt", wrap_up_cnt_o, 0);
      check("rst_dn_cnt", wrap_dn_cnt_o, 0);
    end else begin
      while (cfg_q.size() > 0 && cfg_q[0].due <= cyc) begin
        e_lo = cfg_q[0].lo; e_hi = cfg_q[0].hi; e_err = cfg_q[0].err;
        void'(cfg_q.pop_front());
      end
      check("lower_bound", $signed(lower_bound_o), e_lo);
      check("upper_bound", $signed(upper_bound_o), e_hi);
      check("cfg_err", cfg_err_o, e_err);

      while (trace_q.size() > 0 && trace_q[0].due < cyc) begin
        check("trace_sync", trace_q[0].due, cyc);
        void'(trace_q.pop_front());
      end

      if (trace_q.size() > 0 && trace_q[0].due == cyc) begin
        exp_t e;
        e = trace_q.pop_front();
        if (!e.idle) begin
          held_up = e.up;
          held_dn = e.dn;
        end
        check("acc_clr", acc_clr_o, e.clr);
        check("acc_en", acc_en_o, e.en);
        check("done", done_o, e.done);
        check("busy", busy_o, e.busy);
        check("cfg_ready", cfg_ready_o, !e.busy);
      end else begin
        check("idle_clr", acc_clr_o, 0);
        check("idle_en", acc_en_o, 0);
        check("idle_done", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_ready", cfg_ready_o, 1);
      end
      check("wrap_up_cnt", wrap_up_cnt_o, sat(held_up, (1 << CNT_W) - 1));
      check("wrap_dn_cnt", wrap_dn_cnt_o, sat(held_dn, (1 << CNT_W) - 1));
      check("sat_up_cnt", s_up_cnt, sat(held_up, 3));
      check("sat_dn_cnt", s_dn_cnt, sat(held_dn, 3));
    end
  end

  // -------------------------------------------------------------- stimulus
  logic signed [WIDTH:0] m_lo, m_hi;
  bit                    m_err;
  bit                    up_pat[64];
  bit                    dn_pat[64];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    cfg_valid_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    wrap_up_i = 1'b0; wrap_dn_i = 1'b0; run_len_i = '0;
  endtask

  // Offer a config in the current (idle) cycle; the caller advances time.
  task automatic send_cfg(input logic signed [WIDTH:0] lo, input logic signed [WIDTH:0] hi);
    cfg_exp_t c;
    cfg_valid_i = 1'b1;
    cfg_lower_i = lo;
    cfg_upper_i = hi;
    if (lo < hi) begin
      m_lo = lo; m_hi = hi; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    c.due = cyc + 1; c.lo = m_lo; c.hi = m_hi; c.err = m_err;
    cfg_q.push_back(c);
  endtask

  task automatic random_pats();
    for (int i = 0; i < 64; i++) begin
      up_pat[i] = ($urandom_range(0, 2) == 0);
      dn_pat[i] = ($urandom_range(0, 2) == 0);
    end
  endtask

  // Issue a run starting in the current cycle (entry 0). abort_at/reset_at are
  // entry indices, or -1 for none. noise drives start/cfg traffic while busy.
  task automatic do_run(input int len, input int abort_at, input int reset_at,
                        input bit noise);
    int   n, last, c, up, dn, p;
    exp_t e;
    n    = (len == 0) ? 1 : CLR_CYC + len + PIPE_LAT + 2;
    last = (abort_at >= 1) ? abort_at : n - 1;
    c    = cyc;
    up   = 0;
    dn   = 0;
    if (abort_at >= 1) begin
      up_pat[abort_at] = 1'b0;
      dn_pat[abort_at] = 1'b0;
    end
    if (len != 0) begin
      for (int i = 0; i <= last; i++) begin
        if (reset_at >= 0 && i >= reset_at) break;
        e.due = c + i; e.idle = (i == 0);
        e.clr = 0; e.en = 0; e.done = 0; e.busy = (i != 0);
        e.up = up; e.dn = dn;
        if (i >= 1) begin
          p = i - 1;
          if (p < CLR_CYC) e.clr = 1;
          else if (p < CLR_CYC + len) e.en = 1;
          else if (p == CLR_CYC + len + PIPE_LAT) e.done = 1;
          if (p >= CLR_CYC && p < CLR_CYC + len + PIPE_LAT && i != abort_at) begin
            up += int'(up_pat[i]);
            dn += int'(dn_pat[i]);
          end
        end
        trace_q.push_back(e);
      end
    end
    for (int i = 0; i <= last; i++) begin
      if (i == reset_at) begin
        rstn = 1'b0;
        m_lo = '0; m_hi = (WIDTH+1)'(UP_RST); m_err = 1'b0;
        step();
        clear_inputs();
        rstn = 1'b1;
        return;
      end
      if (i == 0) begin
        start_i   = 1'b1;
        run_len_i = LEN_W'(len);
      end else begin
        start_i     = noise && ($urandom_range(0, 2) == 0);
        run_len_i   = LEN_W'($urandom_range(1, 9));
        cfg_valid_i = noise && ($urandom_range(0, 2) == 0);
        cfg_lower_i = (WIDTH+1)'($urandom);
        cfg_upper_i = (WIDTH+1)'($urandom);
      end
      abort_i   = (i == abort_at);
      wrap_up_i = up_pat[i];
      wrap_dn_i = dn_pat[i];
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rstn = 1'b1;
    cfg_lower_i = '0; cfg_upper_i = '0;
    clear_inputs();
    m_lo = '0; m_hi = (WIDTH+1)'(UP_RST); m_err = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();

    // Valid then degenerate config.
    send_cfg(-(WIDTH+1)'(100), (WIDTH+1)'(500)); step(); clear_inputs(); step();
    send_cfg((WIDTH+1)'(7), (WIDTH+1)'(7));      step(); clear_inputs(); step();

    // Plain run of 4 samples, no wraps.
    for (int i = 0; i < 64; i++) begin up_pat[i] = 0; dn_pat[i] = 0; end
    do_run(4, -1, -1, 1'b0);
    step();

    // run_len=10: three up pulses, one up&dn in RUN, one dn in DRAIN.
    for (int i = 0; i < 64; i++) begin up_pat[i] = 0; dn_pat[i] = 0; end
    up_pat[4] = 1; up_pat[6] = 1; up_pat[8] = 1;
    up_pat[10] = 1; dn_pat[10] = 1;
    dn_pat[13] = 1;
    do_run(10, -1, -1, 1'b0);
    step();

    // Abort in the second RUN cycle, then a config right after.
    random_pats();
    do_run(6, CLR_CYC + 2, -1, 1'b0);
    send_cfg((WIDTH+1)'(5), (WIDTH+1)'(900)); step(); clear_inputs(); step();

    // Zero-length start is ignored; a busy run with start/cfg noise.
    do_run(0, -1, -1, 1'b0); step(); clear_inputs(); step();
    random_pats();
    do_run(7, -1, -1, 1'b1);

    // Config together with start: new bounds active from CLEAR.
    send_cfg(-(WIDTH+1)'(2000), (WIDTH+1)'(30));
    random_pats();
    do_run(5, -1, -1, 1'b0);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      int gap, len, ab;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        abort_i = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 2) == 0)
          send_cfg((WIDTH+1)'($urandom), (WIDTH+1)'($urandom));
        step();
        clear_inputs();
      end
      len = $urandom_range(0, 12);
      ab  = -1;
      if (len != 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, CLR_CYC + len + PIPE_LAT);
      random_pats();
      do_run(len, ab, -1, 1'b1);
    end

    // Reset in the middle of a run, with non-default bounds loaded.
    step();
    send_cfg((WIDTH+1)'(11), (WIDTH+1)'(22)); step(); clear_inputs();
    random_pats();
    do_run(8, -1, CLR_CYC + 3, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
